// File: rtl/seg_pkg.sv
// Character codes, segment patterns and scheduler state type shared by the
// 7-segment message scheduler and its decoder.
package seg_pkg;

  typedef logic [3:0] char_code_t;

  localparam char_code_t D0    = 4'd0;
  localparam char_code_t D1    = 4'd1;
  localparam char_code_t D2    = 4'd2;
  localparam char_code_t D3    = 4'd3;
  localparam char_code_t D4    = 4'd4;
  localparam char_code_t D5    = 4'd5;
  localparam char_code_t D6    = 4'd6;
  localparam char_code_t D7    = 4'd7;
  localparam char_code_t D8    = 4'd8;
  localparam char_code_t D9    = 4'd9;
  localparam char_code_t BLANK = 4'd10;
  localparam char_code_t CH_V  = 4'd11;
  localparam char_code_t CH_E  = 4'd12;
  localparam char_code_t CH_R  = 4'd13;
  localparam char_code_t DASH  = 4'd14;
  localparam char_code_t ERR   = 4'd15;

  typedef enum logic {IDLE, PLAY} sched_state_t;

  // Segment patterns: bit7 = dp, bits 6:0 = gfedcba
  localparam logic [7:0] SEG_D0    = 8'h3F;
  localparam logic [7:0] SEG_D1    = 8'h06;
  localparam logic [7:0] SEG_D2    = 8'h5B;
  localparam logic [7:0] SEG_D3    = 8'h4F;
  localparam logic [7:0] SEG_D4    = 8'h66;
  localparam logic [7:0] SEG_D5    = 8'h6D;
  localparam logic [7:0] SEG_D6    = 8'h7D;
  localparam logic [7:0] SEG_D7    = 8'h07;
  localparam logic [7:0] SEG_D8    = 8'h7F;
  localparam logic [7:0] SEG_D9    = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_V     = 8'h3E;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_R     = 8'h50;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_ERR   = 8'h80;

  // Character idx of a packed message; idx 0 sits in the top nibble.
  function automatic char_code_t msg_char(input logic [15:0] msg, input logic [1:0] idx);
    case (idx)
      2'd0:    return msg[15:12];
      2'd1:    return msg[11:8];
      2'd2:    return msg[7:4];
      default: return msg[3:0];
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational character-code to 7-segment pattern decoder.
module seg7_decode
  import seg_pkg::*;
(
  input  char_code_t  char_code,
  output logic [7:0]  seg
);

  // NOTE: the default assignment before the case keeps every path driven,
  // so no latch is inferred even if a code is left out of the case.
  always_comb begin
    seg = SEG_ERR;
    case (char_code)
      D0:    seg = SEG_D0;
      D1:    seg = SEG_D1;
      D2:    seg = SEG_D2;
      D3:    seg = SEG_D3;
      D4:    seg = SEG_D4;
      D5:    seg = SEG_D5;
      D6:    seg = SEG_D6;
      D7:    seg = SEG_D7;
      D8:    seg = SEG_D8;
      D9:    seg = SEG_D9;
      BLANK: seg = SEG_BLANK;
      CH_V:  seg = SEG_V;
      CH_E:  seg = SEG_E;
      CH_R:  seg = SEG_R;
      DASH:  seg = SEG_DASH;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seg_msg_scheduler.sv
// Round-robin scheduler sharing one 7-segment digit between two 4-character
// message requesters: blank slot, then 4 characters, each held DWELL_CYCLES.
module seg_msg_scheduler
  import seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int CW           = $clog2(DWELL_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] msg0,
  input  logic [15:0] msg1,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        msg_done,
  output char_code_t  char_code,
  output logic [7:0]  seg
);

  localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);

  sched_state_t  state;
  logic [2:0]    slot;
  logic [CW-1:0] cnt;
  logic [15:0]   snap;
  logic          last_served;

  logic          winner;
  logic          start;
  logic          abort_msg;
  logic          advance;
  logic          finish;
  char_code_t    char_next;
  logic [7:0]    seg_next;

  // Slot events are decoded once and shared by the FSM and the display path
  // so seg can be registered from the same next-code as char_code.
  always_comb begin
    winner    = (req == 2'b11) ? ~last_served : req[1];
    start     = (state == IDLE) && (req != 2'b00);
    abort_msg = (state == PLAY) && !req[gnt[1]];
    advance   = (state == PLAY) && !abort_msg && (cnt == '0) && (slot != 3'd4);
    finish    = (state == PLAY) && !abort_msg && (cnt == '0) && (slot == 3'd4);

    char_next = char_code;
    if (start)
      char_next = BLANK;
    else if ((state == IDLE) || abort_msg || finish)
      char_next = DASH;
    else if (advance)
      char_next = msg_char(snap, slot[1:0]);
  end

  seg7_decode u_decode (
    .char_code (char_next),
    .seg       (seg_next)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: snap is deliberately not reset; it is only read after a grant loads it.
      state       <= IDLE;
      gnt         <= 2'b00;
      busy        <= 1'b0;
      msg_done    <= 1'b0;
      char_code   <= DASH;
      seg         <= SEG_DASH;
      last_served <= 1'b1;
      cnt         <= '0;
      slot        <= 3'd0;
    end else begin
      char_code <= char_next;
      seg       <= seg_next;
      msg_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= PLAY;
            gnt         <= winner ? 2'b10 : 2'b01;
            busy        <= 1'b1;
            snap        <= winner ? msg1 : msg0;
            slot        <= 3'd0;
            cnt         <= RELOAD;
            last_served <= winner;
          end
        end
        PLAY: begin
          if (abort_msg || finish) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            busy     <= 1'b0;
            msg_done <= finish;
          end else if (advance) begin
            slot <= slot + 3'd1;
            cnt  <= RELOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_msg_scheduler.sv
// Checks two scheduler instances (dwell 4 and dwell 1) against an
// elapsed-time reference model, with directed scenarios then random traffic.
module tb_seg_msg_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_v [2];
  logic [1:0]  req_v   [2];
  logic [15:0] msg0_v  [2];
  logic [15:0] msg1_v  [2];
  logic [1:0]  gnt_v   [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic [3:0]  cc_v    [2];
  logic [7:0]  seg_v   [2];

  int checks = 0;
  int errors = 0;

  seg_msg_scheduler #(.DWELL_CYCLES(4)) dut_d4 (
    .clk(clk), .rst_n(rst_n_v[0]), .req(req_v[0]), .msg0(msg0_v[0]), .msg1(msg1_v[0]),
    .gnt(gnt_v[0]), .busy(busy_v[0]), .msg_done(done_v[0]), .char_code(cc_v[0]), .seg(seg_v[0])
  );

  seg_msg_scheduler #(.DWELL_CYCLES(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n_v[1]), .req(req_v[1]), .msg0(msg0_v[1]), .msg1(msg1_v[1]),
    .gnt(gnt_v[1]), .busy(busy_v[1]), .msg_done(done_v[1]), .char_code(cc_v[1]), .seg(seg_v[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dwell(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic [7:0] seg_of(input int c);
    case (c)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;  10: return 8'h00; 11: return 8'h3E;
      12: return 8'h79; 13: return 8'h50; 14: return 8'h40; default: return 8'h80;
    endcase
  endfunction

  // Reference model: a message is "active" with an elapsed-cycle count t
  // since its grant; the displayed slot is simply t / dwell.
  bit          m_act  [2] = '{0, 0};
  int          m_own  [2] = '{0, 0};
  logic [15:0] m_msg  [2];
  int          m_t    [2] = '{0, 0};
  int          m_last [2] = '{1, 1};
  bit          m_done [2] = '{0, 0};

  task automatic model_step(input int k);
    int win;
    m_done[k] = 1'b0;
    if (!rst_n_v[k]) begin
      m_act[k]  = 1'b0;
      m_last[k] = 1;
    end else if (!m_act[k]) begin
      if (req_v[k] != 2'b00) begin
        if (req_v[k] == 2'b11) win = 1 - m_last[k];
        else                   win = req_v[k][1] ? 1 : 0;
        m_act[k]  = 1'b1;
        m_own[k]  = win;
        m_msg[k]  = (win == 1) ? msg1_v[k] : msg0_v[k];
        m_t[k]    = 0;
        m_last[k] = win;
      end
    end else if (!req_v[k][m_own[k]]) begin
      m_act[k] = 1'b0;
    end else begin
      m_t[k]++;
      if (m_t[k] == 5 * dwell(k)) begin
        m_act[k]  = 1'b0;
        m_done[k] = 1'b1;
      end
    end
  endtask

  function automatic int model_char(input int k);
    int s;
    if (!m_act[k]) return 14;
    s = m_t[k] / dwell(k);
    if (s == 0) return 10;
    return int'((m_msg[k] >> (4 * (4 - s))) & 16'hF);
  endfunction

  task automatic compare(input int k);
    int c;
    string sfx;
    sfx = $sformatf("_d%0d", dwell(k));
    c = model_char(k);
    check({"gnt", sfx},  32'(gnt_v[k]),  m_act[k] ? 32'(1 << m_own[k]) : 32'd0);
    check({"busy", sfx}, 32'(busy_v[k]), 32'(m_act[k]));
    check({"done", sfx}, 32'(done_v[k]), 32'(m_done[k]));
    check({"char", sfx}, 32'(cc_v[k]),   32'(c));
    check({"seg", sfx},  32'(seg_v[k]),  32'(seg_of(c)));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      compare(0);
      compare(1);
    end
  endtask

  task automatic randomize_inputs(input int k);
    if (rst_n_v[k]) rst_n_v[k] = ($urandom_range(0, 299) != 0);
    else            rst_n_v[k] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (!req_v[k][i])
        req_v[k][i] = ($urandom_range(0, 5) == 0);
      else if (m_done[k] && m_own[k] == i)
        req_v[k][i] = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 79) == 0)
        req_v[k][i] = 1'b0;
    end
    if ($urandom_range(0, 9) == 0) msg0_v[k] = 16'($urandom);
    if ($urandom_range(0, 9) == 0) msg1_v[k] = 16'($urandom);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n_v[k] = 1'b0;
      req_v[k]   = 2'b11;
      msg0_v[k]  = 16'h0000;
      msg1_v[k]  = 16'h0000;
    end

    // Reset held with both requests asserted
    for (int i = 0; i < 3; i++) begin
      run(1);
      check("rst_gnt", 32'(gnt_v[0]), 32'd0);
      check("rst_seg", 32'(seg_v[0]), 32'h40);
    end
    rst_n_v[0] = 1'b1; rst_n_v[1] = 1'b1;
    req_v[0] = 2'b00;  req_v[1] = 2'b00;
    run(1);
    check("post_rst_seg", 32'(seg_v[0]), 32'h40);

    // Single message
    req_v[0] = 2'b01; msg0_v[0] = 16'h1234;
    run(1);
    check("single_gnt", 32'(gnt_v[0]), 32'h1);
    check("single_blank", 32'(seg_v[0]), 32'h00);
    run(4);
    check("single_c0", 32'(seg_v[0]), 32'h06);
    run(16);
    check("single_done", 32'(done_v[0]), 32'd1);
    check("single_dash", 32'(seg_v[0]), 32'h40);
    req_v[0] = 2'b00;
    run(2);

    // Contention from reset
    rst_n_v[0] = 1'b0;
    run(1);
    rst_n_v[0] = 1'b1; req_v[0] = 2'b11;
    msg0_v[0] = 16'h9999; msg1_v[0] = 16'hBCDA;
    run(1);
    check("cont_first", 32'(gnt_v[0]), 32'h1);
    run(20);
    check("cont_done1", 32'(done_v[0]), 32'd1);
    run(1);
    check("cont_second", 32'(gnt_v[0]), 32'h2);
    run(4);
    check("cont_v", 32'(seg_v[0]), 32'h3E);
    run(16);
    run(1);
    check("cont_third", 32'(gnt_v[0]), 32'h1);
    req_v[0] = 2'b00;
    run(2);

    // Snapshot and no pre-emption
    req_v[0] = 2'b01; msg0_v[0] = 16'h1234;
    run(1);
    run(9);
    msg0_v[0] = 16'h0000; req_v[0] = 2'b11;
    run(3);
    check("snap_c2", 32'(seg_v[0]), 32'h4F);
    check("snap_gnt", 32'(gnt_v[0]), 32'h1);
    run(8);
    check("snap_done", 32'(done_v[0]), 32'd1);
    req_v[0] = 2'b00;
    run(2);

    // Abort during slot 3
    req_v[0] = 2'b01; msg0_v[0] = 16'h5678;
    run(1);
    run(13);
    req_v[0] = 2'b00;
    run(1);
    check("abort_gnt", 32'(gnt_v[0]), 32'd0);
    check("abort_seg", 32'(seg_v[0]), 32'h40);
    check("abort_done", 32'(done_v[0]), 32'd0);
    req_v[0] = 2'b01;
    run(1);
    check("regrant_seg", 32'(seg_v[0]), 32'h00);
    req_v[0] = 2'b00;
    run(3);

    // Dwell of one cycle with the error code, reset mid-sequence
    req_v[1] = 2'b01; msg0_v[1] = 16'hF0F0;
    run(1);
    check("d1_blank", 32'(seg_v[1]), 32'h00);
    run(1);
    check("d1_err", 32'(seg_v[1]), 32'h80);
    run(1);
    check("d1_zero", 32'(seg_v[1]), 32'h3F);
    rst_n_v[1] = 1'b0;
    run(1);
    check("d1_rst_seg", 32'(seg_v[1]), 32'h40);
    check("d1_rst_done", 32'(done_v[1]), 32'd0);
    rst_n_v[1] = 1'b1; req_v[1] = 2'b00;
    run(2);

    // Random traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs(0);
      randomize_inputs(1);
      run(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
